param_shift_unit: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit control-coded shift register.
- Shifts data_out by a runtime amount, one bit position per clock, under a start/busy/done handshake.
- Exposes the last bit shifted out on serial_out.
- Used wherever the datapath needs a WIDTH-bit shifter that is small and serial rather than a barrel shifter.

---
 rtl/param_shift_if.sv | 26 ++
 rtl/param_shift_unit.sv | 150 +++++++++++++++
 tb/tb_param_shift_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/param_shift_if.sv
// Handshake/data bundle for param_shift_unit.
// master: start, op, amt, data_in, serial_in out; slave drives data_out, serial_out, busy, done.
interface param_shift_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data_in;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, data_in, serial_in,
        input  data_out, serial_out, busy, done
    );

    modport slave (
        input  start, op, amt, data_in, serial_in,
        output data_out, serial_out, busy, done
    );
endinterface

// File: rtl/param_shift_unit.sv
// Serial WIDTH-bit shifter: one bit position per clock under start/busy/done.
// Ports: clk, rst (sync, active-low), bus (param_shift_if.slave: start/op/amt/data_in/serial_in in; data_out/serial_out/busy/done out).
module param_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input logic          clk,
    input logic          rst,
    param_shift_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_CLEAR = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SRL   = 3'd2;
    localparam logic [2:0] OP_SLL   = 3'd3;
    localparam logic [2:0] OP_SRA   = 3'd4;
    localparam logic [2:0] OP_SIN   = 3'd5;
    localparam logic [2:0] OP_ROR   = 3'd6;
    localparam logic [2:0] OP_ROL   = 3'd7;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic             sout_q, sout_nxt;
    logic             done_q, done_nxt;
    logic [AMT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       op_q, op_nxt;
    logic [WIDTH-1:0] step_d;
    logic             step_s;
    logic             is_shift;
    logic             last_step;

    // Ops 2..7 are all shifts.
    assign is_shift  = bus.op[2] | bus.op[1];
    // A zero count inside SHIFT is unreachable; treat it as final to recover.
    assign last_step = cnt_q <= AMT_W'(1);

    // One 1-bit step of the latched op.
    always_comb begin
        step_d = data_q;
        step_s = sout_q;
        case (op_q)
            OP_SRL: begin
                step_d = {1'b0, data_q[WIDTH-1:1]};
                step_s = data_q[0];
            end
            OP_SLL: begin
                step_d = {data_q[WIDTH-2:0], 1'b0};
                step_s = data_q[WIDTH-1];
            end
            OP_SRA: begin
                step_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_s = data_q[0];
            end
            OP_SIN: begin
                step_d = {data_q[WIDTH-2:0], bus.serial_in};
                step_s = data_q[WIDTH-1];
            end
            OP_ROR: begin
                step_d = {data_q[0], data_q[WIDTH-1:1]};
                step_s = data_q[0];
            end
            OP_ROL: begin
                step_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_s = data_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && is_shift && bus.amt != '0) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_nxt = data_q;
        sout_nxt = sout_q;
        cnt_nxt  = cnt_q;
        op_nxt   = op_q;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_CLEAR) begin
                        data_nxt = '0;
                        sout_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else if (bus.op == OP_LOAD) begin
                        data_nxt = bus.data_in;
                        done_nxt = 1'b1;
                    end else if (bus.amt == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = bus.amt;
                        op_nxt  = bus.op;
                    end
                end
            end
            SHIFT: begin
                data_nxt = step_d;
                sout_nxt = step_s;
                cnt_nxt  = cnt_q - AMT_W'(1);
                if (last_step) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            data_q <= '0;
            sout_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_CLEAR;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            sout_q <= sout_nxt;
            done_q <= done_nxt;
            cnt_q  <= cnt_nxt;
            op_q   <= op_nxt;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.serial_out = sout_q;
    assign bus.busy       = (state == SHIFT);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_param_shift_unit.sv
// Randomized self-checking bench for param_shift_unit.
// Expected trajectories come from an arithmetic model built per accepted op.
module tb_param_shift_unit;
    localparam int W = 8;
    localparam int A = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_shift_if #(.WIDTH(W), .AMT_W(A)) bus ();

    param_shift_unit #(.WIDTH(W), .AMT_W(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int exp_data;
    int exp_sout;
    int exp_busy;
    int exp_done;
    int trace_d[$];
    int trace_s[$];
    bit sin_plan[$];
    int sin_src[$];
    int nb;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-op trajectory from plain arithmetic on the current value.
    function automatic void build(input int o, input int n);
        int d, s, b, m;
        d = exp_data;
        for (int i = 0; i < n; i++) begin
            if (sin_src.size() > 0) b = sin_src.pop_front();
            else b = int'($urandom_range(0, 1));
            sin_plan.push_back(b[0]);
            m = d / 128;
            case (o)
                2: begin s = d % 2; d = d / 2; end
                3: begin s = m; d = (d * 2) % 256; end
                4: begin s = d % 2; d = d / 2 + m * 128; end
                5: begin s = m; d = (d * 2) % 256 + b; end
                6: begin s = d % 2; d = d / 2 + s * 128; end
                default: begin s = m; d = (d * 2) % 256 + m; end
            endcase
            trace_d.push_back(d);
            trace_s.push_back(s);
        end
    endfunction

    task automatic clk_step();
        logic       s_rst, s_start;
        logic [2:0] s_op;
        int         s_amt, s_din;
        if (trace_d.size() > 0) bus.serial_in = sin_plan.pop_front();
        else bus.serial_in = 1'($urandom_range(0, 1));
        s_rst   = rst;
        s_start = bus.start;
        s_op    = bus.op;
        s_amt   = int'(bus.amt);
        s_din   = int'(bus.data_in);
        @(posedge clk);
        exp_done = 0;
        if (!s_rst) begin
            exp_data = 0;
            exp_sout = 0;
            exp_busy = 0;
            trace_d.delete();
            trace_s.delete();
            sin_plan.delete();
        end else if (trace_d.size() > 0) begin
            exp_data = trace_d.pop_front();
            exp_sout = trace_s.pop_front();
            if (trace_d.size() == 0) begin
                exp_busy = 0;
                exp_done = 1;
            end
        end else if (s_start) begin
            case (s_op)
                3'd0: begin exp_data = 0; exp_sout = 0; exp_done = 1; end
                3'd1: begin exp_data = s_din; exp_done = 1; end
                default: begin
                    if (s_amt == 0) exp_done = 1;
                    else begin
                        build(int'(s_op), s_amt);
                        exp_busy = 1;
                    end
                end
            endcase
        end
        #1;
        check("data_out", 32'(bus.data_out), exp_data);
        check("serial_out", 32'(bus.serial_out), exp_sout);
        check("busy", 32'(bus.busy), exp_busy);
        check("done", 32'(bus.done), exp_done);
    endtask

    task automatic run(input logic [2:0] o, input int n, input int din,
                       input int poke, input int rst_at, output int nbusy);
        int guard;
        bus.start   = 1'b1;
        bus.op      = o;
        bus.amt     = A'(n);
        bus.data_in = W'(din);
        clk_step();
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.amt     = A'($urandom);
        bus.data_in = W'($urandom);
        nbusy = int'(bus.busy);
        guard = 0;
        while (exp_busy != 0 && guard < 64) begin
            if (guard == poke) begin
                bus.start   = 1'b1;
                bus.op      = 3'd1;
                bus.data_in = 8'h5A;
            end
            if (guard == rst_at) rst = 1'b0;
            clk_step();
            bus.start = 1'b0;
            rst       = 1'b1;
            nbusy += int'(bus.busy);
            guard++;
        end
        if (guard >= 64) check("timeout", 32'(guard), 0);
    endtask

    initial begin
        exp_data = 0;
        exp_sout = 0;
        exp_busy = 0;
        exp_done = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 3'd0;
        bus.amt       = '0;
        bus.data_in   = '0;
        bus.serial_in = 1'b0;
        clk_step();
        clk_step();
        rst = 1'b1;
        clk_step();

        run(3'd1, 0, 8'hB4, -1, -1, nb);
        check("load_b4", 32'(bus.data_out), 32'hB4);
        run(3'd7, 3, 0, -1, -1, nb);
        check("rol_final", 32'(bus.data_out), 32'hA5);
        check("rol_sout", 32'(bus.serial_out), 1);
        check("rol_busy_cycles", 32'(nb), 3);

        run(3'd1, 0, 8'h81, -1, -1, nb);
        run(3'd4, 4, 0, -1, -1, nb);
        check("sra_final", 32'(bus.data_out), 32'hF8);
        check("sra_sout", 32'(bus.serial_out), 0);
        check("sra_busy_cycles", 32'(nb), 4);

        run(3'd0, 0, 0, -1, -1, nb);
        sin_src = '{1, 0, 1, 1, 0, 0, 1, 0};
        run(3'd5, 8, 0, -1, -1, nb);
        check("sin_final", 32'(bus.data_out), 32'hB2);
        check("sin_sout", 32'(bus.serial_out), 0);

        run(3'd1, 0, 8'hFF, -1, -1, nb);
        run(3'd3, 10, 0, 3, -1, nb);
        check("sll_final", 32'(bus.data_out), 0);
        check("sll_busy_cycles", 32'(nb), 10);

        run(3'd1, 0, 8'hFF, -1, -1, nb);
        run(3'd3, 10, 0, 3, 4, nb);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        run(3'd1, 0, 8'h3C, -1, -1, nb);
        check("after_rst_load", 32'(bus.data_out), 32'h3C);

        run(3'd2, 0, 0, -1, -1, nb);
        check("amt0_done", 32'(bus.done), 1);
        check("amt0_busy_cycles", 32'(nb), 0);
        check("amt0_data", 32'(bus.data_out), 32'h3C);
        run(3'd6, 2, 0, -1, -1, nb);
        check("b2b_ror", 32'(bus.data_out), 32'h0F);

        for (int i = 0; i < 40; i++) begin
            run(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 20)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1,
                nb);
            repeat ($urandom_range(0, 2)) clk_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
